// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronised rx line, mid-bit sampling FSM, no parity, one stop bit.
// Emits a one-cycle rx_valid_o per good frame or frame_err_o when the stop bit is low.
module uart_rx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] rx_data_o,
    output logic                 rx_valid_o,
    output logic                 frame_err_o,
    output logic                 rx_busy_o
);

    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_WIDTH-1:0] HALF_LAST = CNT_WIDTH'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_WIDTH-1:0] BIT_LAST  = CNT_WIDTH'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]     IDX_LAST  = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK_WAIT} state_t;

    logic                 rx_p0, rx_p1, rx_s;
    state_t               state, state_n;
    logic [CNT_WIDTH-1:0] cnt, cnt_n;
    logic [IDX_W-1:0]     idx, idx_n;
    logic [DATA_BITS-1:0] shift, shift_n, data_n;
    logic                 valid_n, err_n;

    // Stage p0/p1: metastability synchroniser, idles high like the line
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_p0 <= 1'b1;
            rx_p1 <= 1'b1;
        end else begin
            rx_p0 <= rx_i;
            rx_p1 <= rx_p0;
        end
    end

    assign rx_s = rx_p1;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            shift       <= '0;
            rx_data_o   <= '0;
            rx_valid_o  <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            idx         <= idx_n;
            shift       <= shift_n;
            rx_data_o   <= data_n;
            rx_valid_o  <= valid_n;
            frame_err_o <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        idx_n   = idx;
        shift_n = shift;
        data_n  = rx_data_o;
        valid_n = 1'b0;
        err_n   = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (!rx_s) state_n = START;
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_n = '0;
                    idx_n = '0;
                    // A high line at mid-start means the edge was a glitch
                    state_n = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_n        = '0;
                    shift_n[idx] = rx_s;
                    idx_n        = idx + 1'b1;
                    if (idx == IDX_LAST) begin
                        idx_n   = '0;
                        state_n = STOP;
                    end
                end
            end
            STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_n = '0;
                    if (rx_s) begin
                        data_n  = shift;
                        valid_n = 1'b1;
                        state_n = IDLE;
                    end else begin
                        err_n   = 1'b1;
                        state_n = BRK_WAIT;
                    end
                end
            end
            BRK_WAIT: begin
                cnt_n = '0;
                if (rx_s) state_n = IDLE;
            end
            default: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

    assign rx_busy_o = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit: table of frames plus
// hand-written glitch, framing-error/break and mid-frame reset sequences.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, rx_busy;

    uart_rx #(.CLKS_PER_BIT(16), .DATA_BITS(8), .CNT_WIDTH(16)) dut (
        .clk_i(clk), .rst_i(rst), .rx_i(rx),
        .rx_data_o(rx_data), .rx_valid_o(rx_valid),
        .frame_err_o(frame_err), .rx_busy_o(rx_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int st_cyc = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    int chg_cnt = 0;
    logic [7:0] prev_data = 8'h00;
    logic [7:0] vq[$];
    int         cq[$];
    logic       bq[$];

    // Pulse monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid) begin
                vq.push_back(rx_data);
                cq.push_back(cyc);
                bq.push_back(rx_busy);
            end
            if (frame_err) err_cnt++;
            if (rx_valid && frame_err) both_cnt++;
            if (rx_data != prev_data && !rx_valid) chg_cnt++;
        end
        prev_data = rx_data;
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input int per, input logic stopv);
        rx = 1'b0;
        st_cyc = cyc;
        repeat (per) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (per) @(negedge clk);
        end
        rx = stopv;
        repeat (per) @(negedge clk);
    endtask

    typedef struct {
        int         per;
        logic [7:0] data;
        logic       stopv;
        int         gap;
        int         exp_valid;
        int         exp_err;
        logic [7:0] exp_data;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int e0;
        int lat;
        tbl[0] = '{16, 8'hA5, 1'b1, 20, 1, 0, 8'hA5};
        tbl[1] = '{16, 8'h00, 1'b1, 0,  1, 0, 8'h00};
        tbl[2] = '{16, 8'hFF, 1'b1, 0,  1, 0, 8'hFF};
        tbl[3] = '{16, 8'h3C, 1'b1, 20, 1, 0, 8'h3C};
        tbl[4] = '{15, 8'hC3, 1'b1, 30, 1, 0, 8'hC3};
        tbl[5] = '{17, 8'hC3, 1'b1, 30, 1, 0, 8'hC3};

        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_data",  int'(rx_data), 0);
        chk("reset_valid", int'(rx_valid), 0);
        chk("reset_err",   int'(frame_err), 0);
        chk("reset_busy",  int'(rx_busy), 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        for (int t = 0; t < 6; t++) begin
            vq.delete(); cq.delete(); bq.delete();
            e0 = err_cnt;
            send_frame(tbl[t].data, tbl[t].per, tbl[t].stopv);
            repeat (tbl[t].gap) @(negedge clk);
            chk($sformatf("vec%0d_pulses", t), vq.size(), tbl[t].exp_valid);
            chk($sformatf("vec%0d_errs", t), err_cnt - e0, tbl[t].exp_err);
            if (vq.size() == 1) begin
                chk($sformatf("vec%0d_data", t), int'(vq[0]), int'(tbl[t].exp_data));
                chk($sformatf("vec%0d_busy_at_pulse", t), int'(bq[0]), 0);
                if (tbl[t].per == 16) begin
                    lat = cq[0] - st_cyc;
                    checks++;
                    if (lat < 154 || lat > 156) begin
                        errors++;
                        $display("FAIL vec%0d_latency actual=%0d required=155+-1", t, lat);
                    end
                end
            end
            chk($sformatf("vec%0d_hold_data", t), int'(rx_data), int'(tbl[t].exp_data));
        end

        // Glitch: 4 cycles low, then high again
        vq.delete();
        e0 = err_cnt;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (2) @(negedge clk);
        chk("glitch_busy_mid", int'(rx_busy), 1);
        repeat (20) @(negedge clk);
        chk("glitch_busy_end", int'(rx_busy), 0);
        chk("glitch_pulses", vq.size(), 0);
        chk("glitch_errs", err_cnt - e0, 0);
        chk("glitch_data", int'(rx_data), 8'hC3);

        // Stop bit low, then a held-low line, then recovery
        vq.delete();
        e0 = err_cnt;
        send_frame(8'h55, 16, 1'b0);
        chk("brk_err_once", err_cnt - e0, 1);
        repeat (40) @(negedge clk);
        chk("brk_err_hold", err_cnt - e0, 1);
        chk("brk_pulses", vq.size(), 0);
        chk("brk_data", int'(rx_data), 8'hC3);
        chk("brk_busy_wait", int'(rx_busy), 1);
        rx = 1'b1;
        repeat (10) @(negedge clk);
        chk("brk_busy_idle", int'(rx_busy), 0);
        send_frame(8'h81, 16, 1'b1);
        repeat (20) @(negedge clk);
        chk("rec_pulses", vq.size(), 1);
        if (vq.size() == 1) chk("rec_data", int'(vq[0]), 8'h81);
        chk("rec_errs", err_cnt - e0, 1);

        // Asynchronous reset in the middle of data bit 4 of 0x99
        vq.delete();
        e0 = err_cnt;
        rx = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = (i == 0 || i == 3) ? 1'b1 : 1'b0;
            repeat (16) @(negedge clk);
        end
        rx = 1'b1;
        repeat (8) @(negedge clk);
        chk("rst_busy_before", int'(rx_busy), 1);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_data",  int'(rx_data), 0);
        chk("rst_async_busy",  int'(rx_busy), 0);
        chk("rst_async_valid", int'(rx_valid), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("rst_no_pulse", vq.size(), 0);
        send_frame(8'h42, 16, 1'b1);
        repeat (20) @(negedge clk);
        chk("post_rst_pulses", vq.size(), 1);
        if (vq.size() == 1) chk("post_rst_data", int'(vq[0]), 8'h42);
        chk("post_rst_errs", err_cnt - e0, 0);

        chk("valid_err_overlap", both_cnt, 0);
        chk("data_changed_without_valid", chg_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver for the FPGA UART: converts the asynchronous rx line into parallel bytes.
- Sits directly upstream of the RX data and status registers.
- rx_data_o/rx_valid_o drive the RX data register's data_periph_i/wr_en_periph_i.
- frame_err_o drives the status register's error bit through the same peripheral write port.
- Uses the mid-bit sampling method, with a cycle counter set by parameter.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per serial bit (100 MHz / 115200); legal range 4..65535.
- DATA_BITS, 8, data bits per frame; legal range 5..8. No parity; one stop bit.
- CNT_WIDTH, 16, bit-counter width; must satisfy 2^CNT_WIDTH > CLKS_PER_BIT.

Ports:
- clk_i  input  1  system clock.
- rst_i  input  1  reset, asynchronous, active-high.
- rx_i  input  1  serial line; idles high; asynchronous to clk_i.
- rx_data_o  output  DATA_BITS  last received byte, LSB = first data bit on the line.
- rx_valid_o  output  1  one-cycle pulse when rx_data_o holds a newly received, correctly framed byte.
- frame_err_o  output  1  one-cycle pulse when the stop bit is sampled low.
- rx_busy_o  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Interface: one clock, clk_i. Reset rst_i is asynchronous and active-high, and acts on every flop, including the synchroniser.
- Reset values:
  - synchroniser flops = 1.
  - rx_data_o = 0.
  - rx_valid_o, frame_err_o, rx_busy_o = 0.
  - FSM = IDLE, bit counter = 0, bit index = 0.
- Input conditioning: rx_i passes through a 2-flop synchroniser. All decisions use the synchronised value rx_s, which lags rx_i by 2 cycles.
- FSM states: IDLE, START, DATA, STOP, BRK_WAIT.
  - IDLE: when rx_s = 0, go to START and clear the counter. Otherwise stay.
  - START: count up. When counter = CLKS_PER_BIT/2 - 1 (integer division), sample rx_s:
    - rx_s = 0: go to DATA, clear the counter, set bit index = 0.
    - rx_s = 1: glitch; return to IDLE with no output pulse.
  - DATA: count up. When counter = CLKS_PER_BIT - 1, sample rx_s into bit[index], clear the counter, and increment the index. After sampling bit DATA_BITS-1, go to STOP.
  - STOP: count up. When counter = CLKS_PER_BIT - 1, sample rx_s:
    - rx_s = 1: on the next clock edge, load rx_data_o with the shifted byte, pulse rx_valid_o for exactly 1 cycle, and go to IDLE.
    - rx_s = 0: on the next edge, pulse frame_err_o for 1 cycle and go to BRK_WAIT. rx_data_o is not updated.
  - BRK_WAIT: stay until rx_s = 1, then go to IDLE. This stops a break condition, or a line held low, from producing repeated frames.
- Sampling point: every bit is sampled at its midpoint, ±1 cycle, measured from the detected falling edge.
- Back-to-back frames: after a good STOP sample the block returns to IDLE. It must accept a start edge that arrives immediately at that point, so there is no dead time beyond the remaining half stop bit.
- Latency: the rx_valid_o pulse occurs 2 (sync) + CLKS_PER_BIT/2 + (DATA_BITS+1)·CLKS_PER_BIT + 1 cycles after the falling edge of the start bit on rx_i. A ±1 cycle tolerance is allowed for the start-detect phase.
- rx_data_o holds its value between frames. It changes only on the cycle rx_valid_o is asserted.
- rx_valid_o and frame_err_o are never asserted in the same cycle.
- No internal buffering. Overrun detection belongs to the downstream register and is out of scope here.
- Counters saturate at no point; they are cleared on every state transition.
- Reset mid-frame: all state returns to reset values immediately, with no pulse emitted. After reset is released, reception resumes with the next falling edge seen in IDLE. If the line is low at release, that low is treated as a start bit.

Test Plan (CLKS_PER_BIT=16, DATA_BITS=8 unless stated):
- Single frame 0xA5 with ideal timing -> one rx_valid_o pulse, rx_data_o = 0xA5, frame_err_o stays 0, rx_busy_o falls with the pulse; pulse cycle matches the latency formula ±1.
- Back-to-back frames 0x00, 0xFF, 0x3C with no idle gap -> three valid pulses, data in order, no errors.
- Glitch: rx_i low for 4 cycles, then high -> FSM returns to IDLE after the START sample, no pulses, rx_data_o unchanged.
- Stop bit driven low on frame 0x55 -> frame_err_o pulses once, rx_valid_o stays 0, rx_data_o keeps the previous value. Holding rx_i low for 40 more cycles gives no further pulses. Releasing the line high and sending 0x81 then receives correctly.
- rst_i asserted asynchronously (between clock edges) during bit 4 of frame 0x99 -> outputs go to reset values immediately. A following frame 0x42 sent after release gives rx_data_o = 0x42 and exactly one pulse.
- Baud tolerance with CLKS_PER_BIT=16: transmitter bit periods of 15 and 17 cycles, frame 0xC3 -> received correctly in both cases.
